// File: rtl/tff_count_sequencer_if.sv
// Command/status bundle for the T flip-flop count sequencer.
// The bench or a parent FSM drives the master side.
interface tff_count_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CW    = 4
);
    logic             Start;
    logic [1:0]       Cmd;
    logic [CW-1:0]    Count;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] T;
    logic             Busy;
    logic             Done;
    logic             Wrap;

    modport master (
        output Start, Cmd, Count, LoadVal,
        input  Q, T, Busy, Done, Wrap
    );

    modport slave (
        input  Start, Cmd, Count, LoadVal,
        output Q, T, Busy, Done, Wrap
    );
endinterface

// File: rtl/tff_count_sequencer.sv
// Sequences a WIDTH-bit T flip-flop bank through up/down/load/clear runs.
// Optional SAT_STOP_EN: a wrapping step is suppressed and ends the run.
module tff_count_sequencer #(
    parameter int WIDTH = 4,
    parameter int CW    = 4
) (
    input logic                  Clock,
    input logic                  Reset,
    tff_count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] C_UP   = 2'b00;
    localparam logic [1:0] C_DOWN = 2'b01;
    localparam logic [1:0] C_LOAD = 2'b10;
    localparam logic [1:0] C_CLR  = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             wrap_q, wrap_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] t_up, t_dn, t_vec;
    logic [CW-1:0]    steps;
    logic             wrap_evt;
    logic             last;

    // Carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic acc_up;
        logic acc_dn;
        acc_up = 1'b1;
        acc_dn = 1'b1;
        t_up   = '0;
        t_dn   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            t_up[i] = acc_up;
            t_dn[i] = acc_dn;
            acc_up  = acc_up & q_q[i];
            acc_dn  = acc_dn & ~q_q[i];
        end
    end

    always_comb begin
        t_vec = '0;
        if (state_q == S_RUN) begin
            unique case (cmd_q)
                C_UP:    t_vec = t_up;
                C_DOWN:  t_vec = t_dn;
                C_LOAD:  t_vec = q_q ^ load_q;
                C_CLR:   t_vec = q_q;
                default: t_vec = '0;
            endcase
        end
    end

    assign wrap_evt = (cmd_q == C_UP   && (&q_q))
                   || (cmd_q == C_DOWN && ~(|q_q));

    assign steps = bus.Cmd[1] ? CW'(1) : bus.Count;

`ifdef SAT_STOP_EN
    assign last = (rem_q == CW'(1)) || wrap_evt;
`else
    assign last = (rem_q == CW'(1));
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        load_d  = load_q;
        rem_d   = rem_q;
        cmd_d   = cmd_q;
        wrap_d  = wrap_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    cmd_d  = bus.Cmd;
                    load_d = bus.LoadVal;
                    wrap_d = 1'b0;
                    rem_d  = steps;
                    if (steps == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                q_d   = q_q ^ t_vec;
                rem_d = rem_q - CW'(1);
                if (wrap_evt) begin
                    wrap_d = 1'b1;
`ifdef SAT_STOP_EN
                    q_d = q_q;
`endif
                end
                if (last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            load_q  <= '0;
            rem_q   <= '0;
            cmd_q   <= C_UP;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            load_q  <= load_d;
            rem_q   <= rem_d;
            cmd_q   <= cmd_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.T    = t_vec;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Wrap = wrap_q;
endmodule

// File: tb/tb_tff_count_sequencer.sv
// Bench for tff_count_sequencer: vector table, directed corners, random runs.
// Expected Q is modelled as plain modular arithmetic on the bank value.
module tb_tff_count_sequencer;
    localparam int W   = 4;
    localparam int CW  = 4;
    localparam int MOD = 1 << W;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    tff_count_sequencer_if #(.WIDTH(W), .CW(CW)) bus ();

    tff_count_sequencer #(.WIDTH(W), .CW(CW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;
    int m_q    = 0;
    int m_wrap = 0;

`ifdef SAT_STOP_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       st;
        logic [1:0] cmd;
        logic [3:0] cnt;
        logic [3:0] ld;
        logic [3:0] q;
        logic [3:0] t;
        logic       busy;
        logic       done;
        logic       wrap;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(
        logic rst, logic st, logic [1:0] cmd,
        logic [3:0] cnt, logic [3:0] ld,
        logic [3:0] q, logic [3:0] t,
        logic busy, logic done, logic wrap
    );
        vec_t v;
        v.rst = rst;  v.st = st;  v.cmd = cmd;
        v.cnt = cnt;  v.ld = ld;  v.q = q;
        v.t = t;  v.busy = busy;  v.done = done;
        v.wrap = wrap;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(logic st, logic [1:0] c,
                         logic [3:0] n, logic [3:0] l);
        bus.Start   = st;
        bus.Cmd     = c;
        bus.Count   = n;
        bus.LoadVal = l;
    endtask

    task automatic chk_out(string nm, int q, int t,
                           int busy, int done, int wrap);
        chk({nm, ".Q"}, 32'(bus.Q), 32'(q));
        chk({nm, ".T"}, 32'(bus.T), 32'(t));
        chk({nm, ".Busy"}, 32'(bus.Busy), 32'(busy));
        chk({nm, ".Done"}, 32'(bus.Done), 32'(done));
        chk({nm, ".Wrap"}, 32'(bus.Wrap), 32'(wrap));
    endtask

    task automatic garble(bit glitch);
        if (glitch)
            drive(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));
        else
            drive(1'b0, 2'b00, 4'd0, 4'd0);
    endtask

    // Issue one command and check every cycle up to the return to IDLE
    task automatic run_cmd(logic [1:0] c, int cnt, int ld, bit glitch);
        int steps;
        int nxt;
        bit wr;
        bit stop;
        steps = c[1] ? 1 : cnt;
        drive(1'b1, c, 4'(cnt), 4'(ld));
        tick();
        m_wrap = 0;
        garble(glitch);
        if (steps == 0) begin
            chk_out("zero_start", m_q, 0, 0, 1, m_wrap);
            tick();
            chk_out("zero_idle", m_q, 0, 0, 0, m_wrap);
            return;
        end
        stop = 1'b0;
        for (int i = 0; i < steps && !stop; i++) begin
            unique case (c)
                2'b00: nxt = (m_q + 1) % MOD;
                2'b01: nxt = (m_q + MOD - 1) % MOD;
                2'b10: nxt = ld;
                default: nxt = 0;
            endcase
            wr = (c == 2'b00 && m_q == MOD - 1)
              || (c == 2'b01 && m_q == 0);
            chk_out("run", m_q, m_q ^ nxt, 1, 0, m_wrap);
            if (wr) m_wrap = 1;
            if (wr && SAT) stop = 1'b1;
            else m_q = nxt;
            tick();
            garble(glitch);
        end
        chk_out("done", m_q, 0, 0, 1, m_wrap);
        tick();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk_out("back_idle", m_q, 0, 0, 0, m_wrap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 2'b00, 4'd5, 4'd0);

        // reset with Start held, up 5, load A, clear
        tab.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 0, 5, 0, 0, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 2, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 3, 7, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 4, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 2, 0, 10, 5, 15, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 10, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 10, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 3, 0, 0, 10, 10, 1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tab[k]) begin
            Reset = tab[k].rst;
            drive(tab[k].st, tab[k].cmd, tab[k].cnt, tab[k].ld);
            tick();
            chk_out($sformatf("tab%0d", k), tab[k].q, tab[k].t,
                    tab[k].busy, tab[k].done, tab[k].wrap);
        end
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        m_q = 0;
        m_wrap = 0;

        // down 3 from Q=1 crosses zero
        run_cmd(2'b10, 0, 1, 0);
        drive(1'b1, 2'b01, 4'd3, 4'd0);
        tick();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        chk_out("dn_s0", 1, 1, 1, 0, 0);
        tick();
        chk_out("dn_s1", 0, 15, 1, 0, 0);
        tick();
        if (SAT) begin
            chk_out("dn_sat", 0, 0, 0, 1, 1);
            m_q = 0;
        end else begin
            chk_out("dn_s2", 15, 1, 1, 0, 1);
            tick();
            chk_out("dn_s3", 14, 0, 0, 1, 1);
            m_q = 14;
        end
        tick();
        chk_out("dn_idle", m_q, 0, 0, 0, 1);
        m_wrap = 1;

        // zero-count start and ignored Start mid-run
        run_cmd(2'b00, 0, 0, 0);
        run_cmd(2'b00, 4, 0, 1);

        // reset sampled at the 3rd step edge of an 8-step up run
        run_cmd(2'b11, 0, 0, 0);
        drive(1'b1, 2'b00, 4'd8, 4'd0);
        tick();
        drive(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
        tick();
        chk_out("rst_pre", 2, 1, 1, 0, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_out("rst_at", 0, 0, 0, 0, 0);
        tick();
        chk_out("rst_after", 0, 0, 0, 0, 0);
        m_q = 0;
        m_wrap = 0;

        // random commands with idle gaps
        for (int r = 0; r < 60; r++) begin
            run_cmd(2'($urandom), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), bit'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                chk_out("idle_hold", m_q, 0, 0, 0, m_wrap);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
